switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-output-port wormhole allocator and credit manager for the NoC switch.
- Input buffers request an outport and VC each cycle; the block grants at most one input per outport.
- Grants are round-robin among head flits and locked from head to tail, gated by per-(outport,VC) downstream credits.
- Drives the crossbar select lines and credit counters used by the switch datapath.

Parameters:
- NUM_BUFFERS, 4, number of requesting input buffers
- NUM_OUTPORTS, 4, number of switch output ports
- NUM_VCS, 2, virtual channels per link
- BUFFER_SIZE, 8, downstream buffer depth per VC; initial credit value

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_BUFFERS  flit waiting at input i
- req_outport  input  NUM_BUFFERS x OUT_W  requested outport (OUT_W = clog2(NUM_OUTPORTS))
- req_vc  input  NUM_BUFFERS x VC_W  requested downstream VC (VC_W = max(1, clog2(NUM_VCS)))
- req_head  input  NUM_BUFFERS  flit is packet head
- req_tail  input  NUM_BUFFERS  flit is packet tail (head&tail = single-flit packet)
- credit_return  input  NUM_OUTPORTS x NUM_VCS  one credit returned by downstream
- grant  output  NUM_BUFFERS  input i's flit transfers this cycle
- xbar_sel  output  NUM_OUTPORTS x IN_W  winning input per outport (IN_W = clog2(NUM_BUFFERS))
- xbar_valid  output  NUM_OUTPORTS  outport carries a flit this cycle
- credit_count  output  NUM_OUTPORTS x NUM_VCS x CNT_W  current credits (CNT_W = clog2(BUFFER_SIZE+1))
- err_credit_ovf  output  1  sticky: credit returned while counter full

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - grant = 0, xbar_valid = 0, xbar_sel = 0, err_credit_ovf = 0.
  - Every credit_count = BUFFER_SIZE.
  - Every outport in IDLE; rr_ptr = 0.
- Latency: grant, xbar_sel and xbar_valid are combinational from current state and requests (zero-cycle). A flit transfers on the rising edge where grant[i] = 1. State, credit and pointer updates take effect on that same edge.
- Eligible(i, o):
  - req_valid[i] && req_outport[i] == o && credit_count[o][req_vc[i]] > 0.
  - In IDLE, additionally req_head[i] == 1.
  - In LOCKED, additionally i == owner[o] and req_vc[i] == lock_vc[o].
- Per-outport FSM:
  - IDLE: scan eligible inputs starting at rr_ptr[o], wrapping modulo NUM_BUFFERS. The first found wins.
    - Win with req_tail=0 -> LOCKED(owner = winner, lock_vc = req_vc); rr_ptr[o] <= winner+1 mod NUM_BUFFERS.
    - Win with req_tail=1 (single-flit packet) -> stay IDLE; rr_ptr advances the same way.
  - LOCKED: only the owner may win.
    - Owner grant with req_tail=1 -> IDLE.
    - Owner stalled (no valid or no credit) -> stay LOCKED, grant=0. Other inputs are never granted.
- Non-head flits requesting an IDLE outport, or non-owners requesting a LOCKED outport: not granted and not an error; they wait.
- An input requests a single outport, so grant[i] is set by at most one outport.
- Credits, per (o,v), each clock:
  - dec = grant to o on vc v; inc = credit_return[o][v].
  - dec && inc -> unchanged.
  - dec only -> minus 1. A grant with 0 credits cannot occur because eligibility requires > 0.
  - inc only -> plus 1. If already BUFFER_SIZE: saturate and set err_credit_ovf (cleared only by rst).
- Reset mid-packet: all locks released, credits restored to BUFFER_SIZE, pointers to 0.
- Locked ownership does not time out.

Decomposition:
- Package switch_alloc_pkg holds:
  - width localparams OUT_W, VC_W, IN_W, CNT_W as functions of the parameters;
  - typedef enum logic {IDLE, LOCKED} alloc_state_t;
  - a typedef struct for per-outport lock state (state, owner, lock_vc).
- One sub-module, rr_arbiter: NUM_BUFFERS-wide request vector plus pointer in, one-hot grant and index out, combinational. Instantiated once per outport.
- Credit counters and FSMs stay in the top level.

Test Plan:
(Configuration for all scenarios: NUM_BUFFERS=4, NUM_OUTPORTS=4, NUM_VCS=2, BUFFER_SIZE=8.)
1. Round-robin head contention:
   - Stimulus: reset; inputs 0,1,2 send single-flit head+tail to outport 2, vc 0, held valid for 3 cycles.
   - Required: grant order 0,1,2; xbar_sel[2] = 0,1,2; credit_count[2][0] goes 8 -> 5.
2. Wormhole lock:
   - Stimulus: input 1 sends a 4-flit packet to outport 0; input 3 requests outport 0 with a head from cycle 2.
   - Required: input 3 is not granted until the cycle after input 1's tail transfers; outport 0 is then IDLE and grants 3.
3. Credit exhaustion:
   - Stimulus: input 0 streams 10 flits to outport 1, vc 1, with no credit_return.
   - Required: 8 grants; counter reaches 0; grant stays 0 and outport remains LOCKED.
   - Then: one credit_return[1][1] pulse -> exactly one further grant next cycle.
4. Simultaneous grant and return:
   - Stimulus: credit at 5; grant and credit_return in the same cycle.
   - Required: count stays 5. A return with count at 8 -> count stays 8 and err_credit_ovf = 1.
5. Reset mid-packet:
   - Stimulus: assert rst while outport 3 is LOCKED with credits at 2.
   - Required: immediately xbar_valid = 0, grant = 0, credits = 8, state IDLE. After release, a fresh head from input 2 is granted.
6. Parallel outports:
   - Stimulus: inputs 0..3 head requests to outports 3,2,1,0 respectively in the same cycle.
   - Required: grant = 4'b1111; xbar_sel = {0,1,2,3} for outports {3,2,1,0}.

Source files
------------

// File: rtl/switch_alloc_pkg.sv
// Shared configuration and types for the NoC switch allocator.
// Holds the switch geometry (buffers, outports, VCs, downstream depth),
// the derived field widths, the per-outport allocation state encoding
// and the lock-state record kept for every output port.
package switch_alloc_pkg;

  localparam int NUM_BUFFERS  = 4;
  localparam int NUM_OUTPORTS = 4;
  localparam int NUM_VCS      = 2;
  localparam int BUFFER_SIZE  = 8;

  localparam int OUT_W = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1;
  localparam int VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int IN_W  = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  typedef enum logic {IDLE, LOCKED} alloc_state_t;

  typedef struct packed {
    alloc_state_t     state;
    logic [IN_W-1:0]  owner;
    logic [VC_W-1:0]  lock_vc;
  } lock_state_t;

  // Round-robin successor of an input index, wrapping at NUM_BUFFERS.
  function automatic logic [IN_W-1:0] next_ptr(input logic [IN_W-1:0] idx);
    if (int'(idx) == NUM_BUFFERS - 1) return '0;
    else return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req  - N-wide request vector
//   ptr  - index of the highest-priority requester this cycle
//   gnt  - one-hot grant (all zero when nothing requests)
//   idx  - index of the granted requester (0 when nothing requests)
//   any  - at least one requester was granted
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int cand;

  // Walk the requesters starting at ptr; the first one seen wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = W'(cand);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output-port wormhole switch allocator with downstream credit tracking.
// Each outport grants at most one input per cycle: round-robin among head
// flits while idle, then locked to the winning input/VC until its tail
// transfers. Grants require a credit on the requested (outport, VC).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_valid/outport/vc/head/tail - per-input flit request
//   credit_return   - per (outport, VC) credit pulse from downstream
//   grant           - per-input transfer strobe (combinational)
//   xbar_sel/valid  - crossbar select and valid per outport (combinational)
//   credit_count    - current credits per (outport, VC)
//   err_credit_ovf  - sticky flag: credit returned to a full counter
module switch_allocator
  import switch_alloc_pkg::*;
(
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_BUFFERS-1:0]                          req_valid,
  input  logic [NUM_BUFFERS-1:0][OUT_W-1:0]               req_outport,
  input  logic [NUM_BUFFERS-1:0][VC_W-1:0]                req_vc,
  input  logic [NUM_BUFFERS-1:0]                          req_head,
  input  logic [NUM_BUFFERS-1:0]                          req_tail,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]            credit_return,
  output logic [NUM_BUFFERS-1:0]                          grant,
  output logic [NUM_OUTPORTS-1:0][IN_W-1:0]               xbar_sel,
  output logic [NUM_OUTPORTS-1:0]                         xbar_valid,
  output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CNT_W-1:0] credit_count,
  output logic                                            err_credit_ovf
);

  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] gnt_by_out;
  logic [NUM_OUTPORTS-1:0]                  ovf_hit;
  logic                                     err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPORTS; gi++) begin : gen_out
      lock_state_t                       lock_reg;
      logic [IN_W-1:0]                   rr_ptr_reg;
      logic [NUM_VCS-1:0][CNT_W-1:0]     credit_reg;
      logic [NUM_BUFFERS-1:0]            elig;
      logic [NUM_BUFFERS-1:0]            arb_gnt;
      logic [IN_W-1:0]                   arb_idx;
      logic                              arb_any;
      logic [VC_W-1:0]                   win_vc;
      logic                              win_tail;
      logic                              ovf;

      // Eligibility: while locked only the owner on its locked VC may
      // compete, so the arbiter returns the owner regardless of rr_ptr.
      always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
          if (req_valid[i] && (req_outport[i] == OUT_W'(gi)) &&
              (credit_reg[req_vc[i]] != '0)) begin
            if (lock_reg.state == IDLE)
              elig[i] = req_head[i];
            else
              elig[i] = (lock_reg.owner == IN_W'(i)) &&
                        (req_vc[i] == lock_reg.lock_vc);
          end
        end
      end

      rr_arbiter #(
        .N (NUM_BUFFERS),
        .W (IN_W)
      ) u_arb (
        .req (elig),
        .ptr (rr_ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
      );

      assign win_vc          = req_vc[arb_idx];
      assign win_tail        = req_tail[arb_idx];
      assign gnt_by_out[gi]  = arb_gnt;
      assign xbar_sel[gi]    = arb_idx;
      assign xbar_valid[gi]  = arb_any;
      assign credit_count[gi] = credit_reg;
      assign ovf_hit[gi]     = ovf;

      // A return that coincides with a grant on the same VC is a net zero
      // change, so it can never overflow even with a full counter.
      always_comb begin
        ovf = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
          if (credit_return[gi][v] && !(arb_any && (win_vc == VC_W'(v))) &&
              (credit_reg[v] == CNT_W'(BUFFER_SIZE)))
            ovf = 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lock_reg   <= '{state: IDLE, owner: '0, lock_vc: '0};
          rr_ptr_reg <= '0;
          credit_reg <= {NUM_VCS{CNT_W'(BUFFER_SIZE)}};
        end else begin
          if (arb_any) begin
            case (lock_reg.state)
              IDLE: begin
                rr_ptr_reg <= next_ptr(arb_idx);
                if (!win_tail) begin
                  lock_reg.state   <= LOCKED;
                  lock_reg.owner   <= arb_idx;
                  lock_reg.lock_vc <= win_vc;
                end
              end
              LOCKED: begin
                if (win_tail) lock_reg.state <= IDLE;
              end
              default: lock_reg.state <= IDLE;
            endcase
          end
          for (int v = 0; v < NUM_VCS; v++) begin
            if (arb_any && (win_vc == VC_W'(v)) && !credit_return[gi][v])
              credit_reg[v] <= credit_reg[v] - 1'b1;
            else if (credit_return[gi][v] && !(arb_any && (win_vc == VC_W'(v))) &&
                     (credit_reg[v] != CNT_W'(BUFFER_SIZE)))
              credit_reg[v] <= credit_reg[v] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Each input names a single outport, so the per-outport grants never
  // overlap and a plain OR merges them.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) grant = grant | gnt_by_out[o];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_reg <= 1'b0;
    else if (|ovf_hit) err_reg <= 1'b1;
  end

  assign err_credit_ovf = err_reg;

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
  import switch_alloc_pkg::*;

  logic                                            clk = 1'b0;
  logic                                            rst;
  logic [NUM_BUFFERS-1:0]                          req_valid;
  logic [NUM_BUFFERS-1:0][OUT_W-1:0]               req_outport;
  logic [NUM_BUFFERS-1:0][VC_W-1:0]                req_vc;
  logic [NUM_BUFFERS-1:0]                          req_head;
  logic [NUM_BUFFERS-1:0]                          req_tail;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]            credit_return;
  logic [NUM_BUFFERS-1:0]                          grant;
  logic [NUM_OUTPORTS-1:0][IN_W-1:0]               xbar_sel;
  logic [NUM_OUTPORTS-1:0]                         xbar_valid;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CNT_W-1:0] credit_count;
  logic                                            err_credit_ovf;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_outport    (req_outport),
    .req_vc         (req_vc),
    .req_head       (req_head),
    .req_tail       (req_tail),
    .credit_return  (credit_return),
    .grant          (grant),
    .xbar_sel       (xbar_sel),
    .xbar_valid     (xbar_valid),
    .credit_count   (credit_count),
    .err_credit_ovf (err_credit_ovf)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arrays of lock flags, owners, pointers, credits.
  bit m_locked [NUM_OUTPORTS];
  int m_owner  [NUM_OUTPORTS];
  int m_lvc    [NUM_OUTPORTS];
  int m_ptr    [NUM_OUTPORTS];
  int m_cred   [NUM_OUTPORTS][NUM_VCS];
  int m_win    [NUM_OUTPORTS];
  bit m_err;

  function automatic void model_reset();
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      m_locked[o] = 1'b0; m_owner[o] = 0; m_lvc[o] = 0; m_ptr[o] = 0;
      for (int v = 0; v < NUM_VCS; v++) m_cred[o][v] = BUFFER_SIZE;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit wants(int i, int o);
    return req_valid[i] && int'(req_outport[i]) == o &&
           m_cred[o][int'(req_vc[i])] > 0;
  endfunction

  function automatic void model_comb();
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      m_win[o] = -1;
      if (m_locked[o]) begin
        if (wants(m_owner[o], o) && int'(req_vc[m_owner[o]]) == m_lvc[o])
          m_win[o] = m_owner[o];
      end else begin
        for (int k = 0; k < NUM_BUFFERS; k++) begin
          int i;
          i = (m_ptr[o] + k) % NUM_BUFFERS;
          if (m_win[o] < 0 && wants(i, o) && req_head[i]) m_win[o] = i;
        end
      end
    end
  endfunction

  function automatic void model_update();
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      int w;
      w = m_win[o];
      if (w >= 0) begin
        if (!m_locked[o]) begin
          m_ptr[o] = (w + 1) % NUM_BUFFERS;
          if (!req_tail[w]) begin
            m_locked[o] = 1'b1; m_owner[o] = w; m_lvc[o] = int'(req_vc[w]);
          end
        end else if (req_tail[w]) begin
          m_locked[o] = 1'b0;
        end
      end
      for (int v = 0; v < NUM_VCS; v++) begin
        bit dec, inc;
        dec = (w >= 0) && int'(req_vc[w]) == v;
        inc = credit_return[o][v];
        if (inc && !dec) begin
          if (m_cred[o][v] == BUFFER_SIZE) m_err = 1'b1;
          else m_cred[o][v]++;
        end else if (dec && !inc) begin
          m_cred[o][v]--;
        end
      end
    end
  endfunction

  logic [3:0] seen_grant, seen_xv;
  logic [7:0] seen_sel;
  logic [3:0] seen_cnt20;

  // One transaction: compare combinational outputs, clock, compare state.
  task automatic step();
    logic [NUM_BUFFERS-1:0]            eg;
    logic [NUM_OUTPORTS-1:0]           ev;
    logic [NUM_OUTPORTS-1:0][IN_W-1:0] es;
    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CNT_W-1:0] ec;
    #1;
    model_comb();
    eg = '0; ev = '0; es = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      if (m_win[o] >= 0) begin
        eg[m_win[o]] = 1'b1; ev[o] = 1'b1; es[o] = IN_W'(m_win[o]);
      end
    end
    check("grant", 32'(grant), 32'(eg));
    check("xbar_valid", 32'(xbar_valid), 32'(ev));
    check("xbar_sel", 32'(xbar_sel), 32'(es));
    seen_grant = grant; seen_xv = xbar_valid; seen_sel = xbar_sel;
    seen_cnt20 = credit_count[2][0];
    $display("[TB] t=%0t valid=%b grant=%b xbar_valid=%b xbar_sel=%h credits=%h",
             $time, req_valid, grant, xbar_valid, xbar_sel, credit_count);
    @(posedge clk);
    model_update();
    #1;
    for (int o = 0; o < NUM_OUTPORTS; o++)
      for (int v = 0; v < NUM_VCS; v++) ec[o][v] = CNT_W'(m_cred[o][v]);
    check("credit_count", 32'(credit_count), 32'(ec));
    check("err_credit_ovf", 32'(err_credit_ovf), 32'(m_err));
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_outport = '0; req_vc = '0;
    req_head = '0; req_tail = '0; credit_return = '0;
  endtask

  task automatic set_req(input int i, input bit v, input int op, input int vc,
                         input bit h, input bit t);
    req_valid[i] = v; req_outport[i] = OUT_W'(op); req_vc[i] = VC_W'(vc);
    req_head[i] = h; req_tail[i] = t;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_xbar_valid", 32'(xbar_valid), 32'h0);
    check("rst_xbar_sel", 32'(xbar_sel), 32'h0);
    check("rst_credits", 32'(credit_count), 32'h8888_8888);
    check("rst_err", 32'(err_credit_ovf), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [7:0] outport;
    logic [3:0] vc;
    logic [3:0] head;
    logic [3:0] tail;
    logic [3:0] exp_grant;
    logic [3:0] exp_xv;
    logic [7:0] exp_sel;
    logic [3:0] exp_cnt20;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int ng;
    // Round-robin contention on outport 2, then all four outports at once.
    tbl[0] = '{4'b0111, 8'h2A, 4'b0000, 4'b0111, 4'b0111, 4'b0001, 4'b0100, 8'h00, 4'd8};
    tbl[1] = '{4'b0111, 8'h2A, 4'b0000, 4'b0111, 4'b0111, 4'b0010, 4'b0100, 8'h10, 4'd7};
    tbl[2] = '{4'b0111, 8'h2A, 4'b0000, 4'b0111, 4'b0111, 4'b0100, 4'b0100, 8'h20, 4'd6};
    tbl[3] = '{4'b1111, 8'h1B, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 8'h1B, 4'd5};
    tbl[4] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'd4};

    rst = 1'b1;
    clear_inputs();
    model_reset();
    do_reset();

    for (int n = 0; n < 5; n++) begin
      req_valid = tbl[n].valid; req_outport = tbl[n].outport; req_vc = tbl[n].vc;
      req_head = tbl[n].head; req_tail = tbl[n].tail;
      step();
      check("tbl_grant", 32'(seen_grant), 32'(tbl[n].exp_grant));
      check("tbl_xbar_valid", 32'(seen_xv), 32'(tbl[n].exp_xv));
      check("tbl_xbar_sel", 32'(seen_sel), 32'(tbl[n].exp_sel));
      check("tbl_cnt_2_0", 32'(seen_cnt20), 32'(tbl[n].exp_cnt20));
    end

    // Wormhole lock: input 3 waits until input 1's tail has transferred.
    do_reset();
    set_req(1, 1, 0, 0, 1, 0); step(); check("s2_head", 32'(seen_grant), 32'h2);
    req_head[1] = 1'b0;        step(); check("s2_body1", 32'(seen_grant), 32'h2);
    set_req(3, 1, 0, 0, 1, 1); step(); check("s2_block", 32'(seen_grant), 32'h2);
    req_tail[1] = 1'b1;        step(); check("s2_tail", 32'(seen_grant), 32'h2);
    req_valid[1] = 1'b0;       step(); check("s2_next_owner", 32'(seen_grant), 32'h8);

    // Credit exhaustion on outport 1 VC 1, then a single returned credit.
    do_reset();
    ng = 0;
    set_req(0, 1, 1, 1, 1, 0);
    for (int n = 0; n < 10; n++) begin
      step();
      ng += int'(seen_grant[0]);
      req_head[0] = 1'b0;
    end
    check("s3_grant_total", 32'(ng), 32'd8);
    check("s3_cnt_zero", 32'(credit_count[1][1]), 32'h0);
    set_req(1, 1, 1, 0, 1, 1); step(); check("s3_still_locked", 32'(seen_grant), 32'h0);
    credit_return[1][1] = 1'b1; step(); check("s3_return_cycle", 32'(seen_grant), 32'h0);
    credit_return[1][1] = 1'b0; step(); check("s3_one_more", 32'(seen_grant), 32'h1);
    step(); check("s3_stall_again", 32'(seen_grant), 32'h0);

    // Simultaneous grant and return; return into a full counter.
    do_reset();
    set_req(0, 1, 1, 0, 1, 1);
    for (int n = 0; n < 3; n++) step();
    check("s4_cnt5", 32'(credit_count[1][0]), 32'd5);
    credit_return[1][0] = 1'b1; step();
    check("s4_dec_inc", 32'(credit_count[1][0]), 32'd5);
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();
    check("s4_full", 32'(credit_count[1][0]), 32'd8);
    check("s4_no_err", 32'(err_credit_ovf), 32'h0);
    step();
    check("s4_saturate", 32'(credit_count[1][0]), 32'd8);
    check("s4_err_set", 32'(err_credit_ovf), 32'h1);
    credit_return = '0; step();
    check("s4_err_sticky", 32'(err_credit_ovf), 32'h1);

    // Reset while outport 3 is locked with two credits left.
    do_reset();
    set_req(2, 1, 3, 0, 1, 0); step();
    req_head[2] = 1'b0;
    for (int n = 0; n < 5; n++) step();
    check("s5_cnt2", 32'(credit_count[3][0]), 32'd2);
    rst = 1'b1;
    #1;
    model_reset();
    check("s5_grant", 32'(grant), 32'h0);
    check("s5_xbar_valid", 32'(xbar_valid), 32'h0);
    check("s5_credits", 32'(credit_count), 32'h8888_8888);
    @(negedge clk); rst = 1'b0; @(posedge clk); #1;
    step(); check("s5_body_idle", 32'(seen_grant), 32'h0);
    req_head[2] = 1'b1; step(); check("s5_fresh_head", 32'(seen_grant), 32'h4);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = NUM_BUFFERS'($urandom);
      req_head  = NUM_BUFFERS'($urandom);
      req_tail  = NUM_BUFFERS'($urandom) & NUM_BUFFERS'($urandom);
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        req_outport[i] = OUT_W'($urandom_range(0, NUM_OUTPORTS - 1));
        req_vc[i]      = VC_W'($urandom_range(0, NUM_VCS - 1));
      end
      for (int o = 0; o < NUM_OUTPORTS; o++)
        for (int v = 0; v < NUM_VCS; v++)
          credit_return[o][v] = ($urandom_range(0, 5) == 0);
      step();
      if (c % 500 == 499) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
